bin_a_bcd: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock.
- Consumes the signed product and done pulse from the Booth multiplier.
- Produces the 21-bit sign-plus-5-digit BCD code that drives display_7segmentos.
- Acts as the reader side of the multiplier's Mult/done result interface.

---
 rtl/booth_pkg.sv | 10 +
 rtl/ajuste_bcd.sv | 20 ++
 rtl/bin_a_bcd.sv | 118 +++++++++++
 tb/tb_bin_a_bcd.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants and types for the Booth multiplier result path and its BCD converter.
package booth_pkg;

    localparam int unsigned ANCHO_PRODUCTO = 16;
    localparam int unsigned DIGITOS_BCD    = 5;
    localparam logic [3:0]  BCD_BLANK      = 4'hF;

    typedef enum logic [0:0] {IDLE, CONV} estado_bcd_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Combinational double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
module ajuste_bcd
    import booth_pkg::*;
#(
    parameter int unsigned DIGITOS = DIGITOS_BCD
) (
    input  logic [4*DIGITOS-1:0] entrada,
    output logic [4*DIGITOS-1:0] salida
);

    always_comb begin
        salida = entrada;
        for (int i = 0; i < int'(DIGITOS); i++) begin
            if (entrada[4*i +: 4] >= 4'd5) begin
                salida[4*i +: 4] = entrada[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bin_a_bcd.sv
// Sequential signed binary to sign+BCD converter, one double-dabble shift per clock.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with the display blank code.
module bin_a_bcd
    import booth_pkg::*;
#(
    parameter int unsigned ANCHO_BIN = ANCHO_PRODUCTO,
    parameter int unsigned DIGITOS   = DIGITOS_BCD
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [ANCHO_BIN-1:0] Mult,
    output logic [4*DIGITOS:0]   codigo_BCD,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = $clog2(ANCHO_BIN + 1);
    localparam int unsigned BCD_W = 4 * DIGITOS;

    estado_bcd_t          state_q, state_d;
    logic                 sign_q, sign_d;
    logic [ANCHO_BIN-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]     scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W:0]       codigo_q, codigo_d;
    logic                 done_q, done_d;

    logic [BCD_W-1:0]     ajustado;
    logic [BCD_W-1:0]     desplazado;
    logic [BCD_W-1:0]     visible;

    ajuste_bcd #(
        .DIGITOS (DIGITOS)
    ) u_ajuste (
        .entrada (scratch_q),
        .salida  (ajustado)
    );

    // Next MSB of the magnitude shifts into the BCD scratch.
    assign desplazado = {ajustado[BCD_W-2:0], mag_q[ANCHO_BIN-1]};

`ifdef LEADING_ZERO_BLANK_EN
    logic ceros;

    // Units digit is never blanked, so the loop stops at digit 1.
    always_comb begin
        visible = desplazado;
        ceros   = 1'b1;
        for (int i = int'(DIGITOS) - 1; i >= 1; i--) begin
            if (ceros && (desplazado[4*i +: 4] == 4'd0)) begin
                visible[4*i +: 4] = BCD_BLANK;
            end else begin
                ceros = 1'b0;
            end
        end
    end
`else
    assign visible = desplazado;
`endif

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        codigo_d  = codigo_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    sign_d    = Mult[ANCHO_BIN-1];
                    mag_d     = Mult[ANCHO_BIN-1] ? (~Mult + 1'b1) : Mult;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = desplazado;
                mag_d     = {mag_q[ANCHO_BIN-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ANCHO_BIN - 1)) begin
                    codigo_d = {sign_q, visible};
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            codigo_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            codigo_q  <= codigo_d;
            done_q    <= done_d;
        end
    end

    assign codigo_BCD = codigo_q;
    assign busy       = (state_q == CONV);
    assign done       = done_q;

endmodule

// File: tb/tb_bin_a_bcd.sv
// Scoreboard bench for bin_a_bcd: arithmetic reference model, randomized and directed stimulus.
module tb_bin_a_bcd;

    localparam int LAT = 16;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [15:0] mult;
    logic [20:0] codigo_bcd;
    logic        busy;
    logic        done;

    typedef struct {
        logic [20:0] code;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          last_cap;
    bit          have_cap;
    bit          mon_en;
    logic [20:0] last_code;
    int          vectors;
    int          miscompares;

    bin_a_bcd dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .valid      (valid),
        .Mult       (mult),
        .codigo_BCD (codigo_bcd),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sign plus decimal digits of |m|, computed with plain arithmetic.
    function automatic logic [20:0] modelo(input logic [15:0] m);
        int          v;
        int          mag;
        int          pot;
        int          d;
        logic [20:0] r;
        v     = int'($signed(m));
        mag   = (v < 0) ? -v : v;
        r     = '0;
        r[20] = (v < 0);
        pot   = 1;
        for (int i = 0; i < 5; i++) begin
            d = (mag / pot) % 10;
            r[4*i +: 4] = d[3:0];
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && mag < pot) r[4*i +: 4] = 4'hF;
`endif
            pot = pot * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [15:0] v);
        valid = 1'b1;
        mult  = v;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b0;
        sb.delete();
        have_cap  = 1'b0;
        last_code = '0;
        repeat (cycles) tick();
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (sb.size() == 0 && !(have_cap && (cyc - last_cap) < LAT)) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        if (!idle) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle timeout at cycle %0d: pending %0d, expected 0", cyc, sb.size());
            sb.delete();
        end
    endtask

    // Model of which edges accept a start, and when the result is due.
    initial begin
        cyc      = 0;
        last_cap = 0;
        have_cap = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                if (valid && !(have_cap && (cyc - last_cap) < LAT)) begin
                    sb.push_back('{code: modelo(mult), due: cyc + 1 + LAT});
                    last_cap = cyc + 1;
                    have_cap = 1'b1;
                end
                cyc++;
            end
        end
    end

    // Monitor: compares busy, done timing and codigo_BCD every cycle.
    initial begin
        exp_t e;
        bit   busy_exp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                busy_exp = reset && have_cap && ((cyc - last_cap) < LAT);
                check("busy", 32'(busy), 32'(busy_exp));
                if (done) begin
                    if (sb.size() == 0) begin
                        check("done_unexpected", 32'(done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("done_latency", cyc, e.due);
                        last_code = e.code;
                    end
                end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                    check("done_missing", 32'(done), 32'd1);
                    void'(sb.pop_front());
                end
                check("codigo_BCD", 32'(codigo_bcd), 32'(last_code));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_code   = '0;
        mon_en      = 1'b0;
        valid       = 1'b0;
        mult        = '0;
        reset       = 1'b1;
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        pulse(16'd0);     wait_idle();
        pulse(16'd12345); wait_idle();
        pulse(16'hFFFF);  wait_idle();
        pulse(16'h8000);  wait_idle();
        pulse(16'd16384); wait_idle();
        pulse(16'd42);    wait_idle();
        pulse(16'hFFFB);  wait_idle();

        // Reset in the middle of a conversion discards it.
        pulse(16'd999);
        repeat (8) tick();
        do_reset(2);
        tick();
        pulse(16'd999);   wait_idle();

        // Starts at E5 and E16 fall while busy and are dropped.
        pulse(16'd42);
        repeat (4) tick();
        pulse(16'd7);
        repeat (10) tick();
        pulse(16'd9);
        wait_idle();

        // valid held high with Mult changing every cycle.
        valid = 1'b1;
        for (int k = 0; k < 4 * (LAT + 1); k++) begin
            mult = 16'($urandom);
            tick();
        end
        valid = 1'b0;
        wait_idle();

        for (int k = 0; k < 30; k++) begin
            pulse(16'($urandom));
            repeat ($urandom_range(0, 20)) tick();
        end
        wait_idle();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
